// File: rtl/branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_unit
// Purpose  : EX-stage branch resolution with a 1-entry output buffer and
//            saturating branch/mispredict statistics.
// Revision : 1.0 - initial release
// ============================================================================
module branch_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic             pred_taken,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic [XLEN-1:0]  target,
    output logic [XLEN-1:0]  next_pc,
    output logic             mispredict,
    output logic             illegal,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic             r_valid;
    logic             r_taken;
    logic [XLEN-1:0]  r_target;
    logic [XLEN-1:0]  r_next_pc;
    logic             r_mispredict;
    logic             r_illegal;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic             w_eq;
    logic             w_lt_s;
    logic             w_lt_u;
    logic             w_taken;
    logic             w_illegal;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_pc_plus4;
    logic             w_accept;
    logic             w_xfer;

    assign w_eq       = (rs1 == rs2);
    assign w_lt_s     = ($signed(rs1) < $signed(rs2));
    assign w_lt_u     = (rs1 < rs2);
    assign w_target   = pc + imm;
    assign w_pc_plus4 = pc + XLEN'(4);

    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        case (funct3)
            3'b000:  w_taken = w_eq;
            3'b001:  w_taken = !w_eq;
            3'b100:  w_taken = w_lt_s;
            3'b101:  w_taken = !w_lt_s;
            3'b110:  w_taken = w_lt_u;
            3'b111:  w_taken = !w_lt_u;
            default: w_illegal = 1'b1;
        endcase
    end

    // A flush voids both the accept and any transfer happening in the same cycle.
    assign in_ready = !flush && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_xfer   = r_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_taken      <= 1'b0;
            r_target     <= '0;
            r_next_pc    <= '0;
            r_mispredict <= 1'b0;
            r_illegal    <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid      <= 1'b1;
            r_taken      <= w_taken;
            r_target     <= w_target;
            r_next_pc    <= w_taken ? w_target : w_pc_plus4;
            r_mispredict <= w_taken ^ pred_taken;
            r_illegal    <= w_illegal;
        end else if (w_xfer) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (w_xfer) begin
            if (r_branch_cnt != c_cnt_max) begin
                r_branch_cnt <= r_branch_cnt + 1'b1;
            end
            if (r_mispredict && (r_mispred_cnt != c_cnt_max)) begin
                r_mispred_cnt <= r_mispred_cnt + 1'b1;
            end
        end
    end

    assign out_valid   = r_valid;
    assign taken       = r_taken;
    assign target      = r_target;
    assign next_pc     = r_next_pc;
    assign mispredict  = r_mispredict;
    assign illegal     = r_illegal;
    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule
`default_nettype wire
